// File: rtl/instruction_fetch.sv
// instruction_fetch: single-entry fetch stage with a PC, a ready/valid hand-off to decode,
// a redirect flush and a sticky misaligned-target fault.
module instruction_fetch #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [ADDRESS_WIDTH-1:0] imem_address,
    input  logic [DATA_WIDTH-1:0]    imem_instruction,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_target,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDRESS_WIDTH-1:0] out_pc,
    output logic [ADDRESS_WIDTH-1:0] out_pc_plus4,
    output logic [DATA_WIDTH-1:0]    out_instruction,
    output logic                     fault,
    output logic [ADDRESS_WIDTH-1:0] fault_addr
);
    typedef enum logic {FETCH, FAULT} state_t;
    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h00000013);
    state_t r_state, w_state_next;
    logic [ADDRESS_WIDTH-1:0] r_pc, r_out_pc, r_out_pc_plus4, r_fault_addr;
    logic [DATA_WIDTH-1:0] r_out_instruction;
    logic r_out_valid, r_fault;
    logic w_redirect, w_misaligned, w_load_en;
    always_comb begin
        w_misaligned = redirect_target[1:0] != 2'b00;
        w_redirect   = (r_state == FETCH) && redirect_valid;
        w_load_en    = (r_state == FETCH) && (!r_out_valid || out_ready);
        w_state_next = (w_redirect && w_misaligned) ? FAULT : r_state;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= FETCH;
        else r_state <= w_state_next;
    end
    // Redirect wins over both stall and normal fetch; the held word is dropped either way.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc              <= RESET_PC;
            r_out_valid       <= 1'b0;
            r_out_pc          <= '0;
            r_out_pc_plus4    <= '0;
            r_out_instruction <= NOP;
            r_fault           <= 1'b0;
            r_fault_addr      <= '0;
        end else if (w_redirect) begin
            r_out_valid <= 1'b0;
            if (w_misaligned) begin
                r_fault      <= 1'b1;
                r_fault_addr <= redirect_target;
            end else begin
                r_pc <= redirect_target;
            end
        end else if (w_load_en) begin
            r_out_valid       <= 1'b1;
            r_out_pc          <= r_pc;
            r_out_pc_plus4    <= r_pc + ADDRESS_WIDTH'(4);
            r_out_instruction <= imem_instruction;
            r_pc              <= r_pc + ADDRESS_WIDTH'(4);
        end
    end
    assign imem_address    = r_pc;
    assign out_valid       = r_out_valid;
    assign out_pc          = r_out_pc;
    assign out_pc_plus4    = r_out_pc_plus4;
    assign out_instruction = r_out_instruction;
    assign fault           = r_fault;
    assign fault_addr      = r_fault_addr;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: randomized stimulus with a transaction-level fetch model; a negedge
// monitor pops expected accepted PCs from a scoreboard queue on every handshake.
module tb_instruction_fetch;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    logic [31:0] imem_address, imem_instruction, redirect_target = '0;
    logic [31:0] out_pc, out_pc_plus4, out_instruction, fault_addr;
    logic redirect_valid = 1'b0, out_ready = 1'b0, out_valid, fault;
    logic [31:0] d2_addr, d2_instr, d2_pc, d2_pc4, d2_ins, d2_faddr;
    logic d2_valid, d2_fault;
    int n_checks = 0, n_errors = 0;
    logic [31:0] q[$];
    logic mon_en = 1'b0;
    logic m_valid, m_fault;
    logic [31:0] m_held, m_next, m_faddr;
    logic [31:0] rom [8] = '{32'h00500093, 32'h00300113, 32'h002081b3, 32'h40218233,
                             32'h00a00293, 32'h0042a313, 32'hfe000ee3, 32'h00008463};

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a < 32'h20) ? rom[a[4:2]] : ((a * 32'h9E3779B1) ^ 32'h13);
    endfunction

    assign imem_instruction = mem_f(imem_address);
    assign d2_instr = mem_f(d2_addr);

    instruction_fetch dut (
        .clk(clk), .rst(rst), .imem_address(imem_address), .imem_instruction(imem_instruction),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_pc_plus4(out_pc_plus4), .out_instruction(out_instruction),
        .fault(fault), .fault_addr(fault_addr)
    );

    instruction_fetch #(.RESET_PC(32'hFFFFFFFC)) dut_wrap (
        .clk(clk), .rst(rst), .imem_address(d2_addr), .imem_instruction(d2_instr),
        .redirect_valid(1'b0), .redirect_target(32'h0),
        .out_valid(d2_valid), .out_ready(1'b1), .out_pc(d2_pc),
        .out_pc_plus4(d2_pc4), .out_instruction(d2_ins),
        .fault(d2_fault), .fault_addr(d2_faddr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_fault = 1'b0;
        m_held  = '0;
        m_next  = '0;
        m_faddr = '0;
        q.delete();
    endtask

    // Drive one cycle of inputs, predict the edge's effect, then advance to just past the edge.
    task automatic step(input logic rdy, input logic rv, input logic [31:0] tgt);
        logic nv = m_valid, nf = m_fault;
        logic [31:0] nh = m_held, nn = m_next, na = m_faddr;
        out_ready = rdy;
        redirect_valid = rv;
        redirect_target = tgt;
        if (!m_fault) begin
            if (m_valid && rdy) q.push_back(m_held);
            if (rv && tgt[1:0] != 2'b00) begin
                nf = 1'b1;
                na = tgt;
                nv = 1'b0;
            end else if (rv) begin
                nv = 1'b0;
                nn = tgt;
            end else if (!m_valid || rdy) begin
                nv = 1'b1;
                nh = m_next;
                nn = m_next + 32'd4;
            end
        end
        @(posedge clk);
        #1;
        m_valid = nv;
        m_fault = nf;
        m_held  = nh;
        m_next  = nn;
        m_faddr = na;
    endtask

    function automatic logic [31:0] rand_target();
        return ($urandom_range(0, 3) == 0) ? ($urandom() & 32'hFFFFFFFC) : {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    endfunction

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("imem_address", imem_address, m_next);
            chk("fault", 32'(fault), 32'(m_fault));
            chk("fault_addr", fault_addr, m_faddr);
            if (m_valid) chk("held_pc", out_pc, m_held);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_handshake: got pc %h expected no handshake", out_pc);
                end else begin
                    logic [31:0] e;
                    e = q.pop_front();
                    chk("hs_pc", out_pc, e);
                    chk("hs_instr", out_instruction, mem_f(e));
                    chk("hs_pc_plus4", out_pc_plus4, e + 32'd4);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_pc_plus4", out_pc_plus4, 32'd0);
        chk("rst_instr", out_instruction, 32'h00000013);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_fault_addr", fault_addr, 32'd0);
        chk("rst_addr", imem_address, 32'd0);
        chk("rst_wrap_addr", d2_addr, 32'hFFFFFFFC);
        @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        // Program walk, then a three-cycle stall at pc 0x8
        step(1'b1, 1'b0, '0);
        chk("first_instr", out_instruction, 32'h00500093);
        chk("wrap_first_pc", d2_pc, 32'hFFFFFFFC);
        chk("wrap_first_pc4", d2_pc4, 32'h00000000);
        step(1'b1, 1'b0, '0);
        chk("second_instr", out_instruction, 32'h00300113);
        chk("wrap_second_pc", d2_pc, 32'h00000000);
        step(1'b1, 1'b0, '0);
        repeat (3) step(1'b0, 1'b0, '0);
        chk("stall_pc", out_pc, 32'h8);
        chk("stall_instr", out_instruction, 32'h002081b3);
        chk("stall_addr", imem_address, 32'hC);
        step(1'b1, 1'b0, '0);
        chk("after_stall_instr", out_instruction, 32'h40218233);
        // Redirect while stalled
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 32'h1C);
        chk("flush_valid", 32'(out_valid), 32'd0);
        step(1'b1, 1'b0, '0);
        chk("redir_pc", out_pc, 32'h1C);
        chk("redir_instr", out_instruction, 32'h00008463);
        chk("redir_pc4", out_pc_plus4, 32'h20);
        // Random traffic with aligned redirects
        repeat (300) step($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, rand_target());
        // Asynchronous reset in the middle of a stall
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        #2 rst = 1'b1;
        #1;
        chk("async_valid", 32'(out_valid), 32'd0);
        chk("async_instr", out_instruction, 32'h00000013);
        chk("async_addr", imem_address, 32'd0);
        chk("async_pc", out_pc, 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) step($urandom_range(0, 1), 1'b0, '0);
        // Misaligned redirect: sticky fault that ignores later redirects
        step(1'b1, 1'b1, 32'h2);
        repeat (12) step($urandom_range(0, 1), 1'b1, rand_target());
        chk("fault_sticky", 32'(fault), 32'd1);
        chk("fault_addr_sticky", fault_addr, 32'h2);
        chk("fault_valid", 32'(out_valid), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("fault_cleared", 32'(fault), 32'd0);
        chk("fault_addr_cleared", fault_addr, 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) step($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, rand_target());
        repeat (3) step(1'b1, 1'b0, '0);
        chk("queue_drained", 32'(q.size()), 32'd0);
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, instruction word width.
REQ-002 The block SHALL have parameter ADDRESS_WIDTH, default 32, PC and address width.
REQ-003 The block SHALL have parameter RESET_PC, default 32'h00000000, first fetch address; RESET_PC[1:0] must be 2'b00.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-006 The block SHALL have port imem_address, output, ADDRESS_WIDTH, byte address to instruction_memory.
REQ-007 The block SHALL have port imem_instruction, input, DATA_WIDTH, combinational read data returned in the same cycle.
REQ-008 The block SHALL have port redirect_valid, input, 1, branch/jump redirect request.
REQ-009 The block SHALL have port redirect_target, input, ADDRESS_WIDTH, redirect byte address.
REQ-010 The block SHALL have port out_valid, output, 1, fetched instruction available to decode.
REQ-011 The block SHALL have port out_ready, input, 1, decode accepts the fetched instruction.
REQ-012 The block SHALL have ports out_pc and out_pc_plus4, output, ADDRESS_WIDTH, PC of the held instruction and that PC + 4.
REQ-013 The block SHALL have port out_instruction, output, DATA_WIDTH, held instruction word.
REQ-014 The block SHALL have ports fault, output, 1, and fault_addr, output, ADDRESS_WIDTH, for misaligned-target fault status.

Function
REQ-015 The block SHALL hold a PC register and drive imem_address = PC combinationally.
REQ-016 The block SHALL implement an FSM with states FETCH and FAULT; the state is FETCH after reset.
REQ-017 The block SHALL define load_en = (!out_valid || out_ready) in FETCH.
REQ-018 In FETCH with load_en and no redirect, each edge SHALL register out_pc=PC, out_instruction=imem_instruction, out_pc_plus4=PC+4, and out_valid=1, and SHALL set PC<=PC+4.
REQ-019 A handshake SHALL complete when out_valid && out_ready are high on the same edge; a new instruction loads on that same edge, so throughput is one instruction per cycle.
REQ-020 When out_valid=1 and out_ready=0 (stall), the block SHALL hold PC, out_* and imem_address unchanged.
REQ-021 Redirect SHALL have priority over stall and normal fetch: if redirect_valid=1 and redirect_target[1:0]=0, on the next edge the block SHALL set PC<=redirect_target and out_valid<=0 (flush), irrespective of out_ready.
REQ-022 The first instruction after a redirect SHALL appear with out_valid=1 one edge after the flush edge, giving a redirect latency of 2 edges.
REQ-023 If redirect_valid=1 and redirect_target[1:0]!=0, on the next edge the block SHALL enter FAULT with fault<=1, fault_addr<=redirect_target, and out_valid<=0.
REQ-024 In FAULT the block SHALL hold PC, keep out_valid=0, and ignore redirect_valid; only rst leaves FAULT.
REQ-025 PC arithmetic SHALL be modulo 2^ADDRESS_WIDTH, so 32'hFFFFFFFC+4 wraps to 32'h00000000 with no flag.
REQ-026 The first valid instruction SHALL appear on the first rising edge after rst deasserts: out_pc=RESET_PC.

Reset
REQ-027 While rst=1, independent of clk, the block SHALL force PC=RESET_PC, state=FETCH, out_valid=0, out_pc=0, out_pc_plus4=0, out_instruction=32'h00000013 (NOP), fault=0, and fault_addr=0.
REQ-028 Reset asserted mid-stall, mid-redirect or in FAULT SHALL clear all state immediately, and any in-flight instruction SHALL be discarded.

Verification
REQ-029 Memory loaded with 00500093, 00300113, 002081b3, 40218233, ..., 00008463 at 0x1C; release rst with out_ready=1 -> edge 1: out_valid=1, out_pc=0x0, instr 0x00500093; edge 2: out_pc=0x4, instr 0x00300113; one instruction per edge.
REQ-030 Set out_ready=0 for 3 cycles while out_pc=0x8 (instr 0x002081b3) -> out_pc, out_instruction and imem_address=0x0C are held; restore out_ready -> the next edge gives out_pc=0x0C, instr 0x40218233.
REQ-031 Pulse redirect_valid=1 with target 0x1C while out_valid=1 and out_ready=0 -> next edge out_valid=0; following edge out_pc=0x1C, instr 0x00008463, out_pc_plus4=0x20.
REQ-032 Redirect with target 0x00000002 -> fault=1, fault_addr=0x2, out_valid stays 0 for 10+ cycles, and later redirects are ignored; rst then clears fault.
REQ-033 With RESET_PC=32'hFFFFFFFC -> the first out_pc is 0xFFFFFFFC with out_pc_plus4=0x0, and the next out_pc is 0x00000000.
REQ-034 Assert rst between clock edges during a stall -> out_valid=0, out_instruction=0x00000013 and imem_address=RESET_PC immediately, without waiting for an edge.
